// File: rtl/lmc_cpu.sv
// Little Man Computer core: fetches decimal instructions from a 100-word memory,
// executes them in two cycles each, and talks to the outside world through INP/OUT handshakes.
module lmc_cpu #(
  parameter int MEM_WORDS = 100,
  parameter int DATA_MAX  = 999
) (
  input  logic        clk,
  input  logic        reset,
  output logic [6:0]  mem_addr,
  output logic [10:0] mem_wdata,
  output logic        mem_we,
  input  logic [10:0] mem_rdata,
  input  logic [10:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic        illegal,
  output logic [6:0]  pc,
  output logic [10:0] acc
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_INPUT  = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic signed [12:0] LIMIT     = 13'(DATA_MAX);
  localparam logic signed [12:0] MODULUS   = 13'(DATA_MAX + 1);
  localparam logic [10:0]        CLAMP     = 11'(DATA_MAX);
  localparam logic [6:0]         LAST_ADDR = 7'(MEM_WORDS - 1);

  // Operands above DATA_MAX are used unmasked, so a single correction step is not
  // enough; three steps cover the full -2047..3046 range of sum and difference.
  function automatic logic [10:0] wrap_data(input logic signed [12:0] x);
    logic signed [12:0] r;
    r = x;
    for (int k = 0; k < 3; k++) begin
      if (r > LIMIT)
        r = r - MODULUS;
      else if (r < 13'sd0)
        r = r + MODULUS;
    end
    return r[10:0];
  endfunction

  function automatic logic [10:0] sat_data(input logic [10:0] v);
    return (v > CLAMP) ? CLAMP : v;
  endfunction

  logic [2:0]         state;
  logic               neg;
  logic [10:0]        ir;
  logic [4:0]         op;
  logic [6:0]         operand;
  logic               addr_from_pc;
  logic signed [12:0] sum;
  logic signed [12:0] diff;

  always_comb begin
    op           = 5'(ir / 11'd100);
    operand      = 7'(ir % 11'd100);
    addr_from_pc = (ir == 11'd901) || (ir == 11'd902) || (ir == 11'd0);
    sum          = $signed({2'b00, acc}) + $signed({2'b00, mem_rdata});
    diff         = $signed({2'b00, acc}) - $signed({2'b00, mem_rdata});
  end

  always_comb begin
    mem_addr = pc;
    if (state == S_EXEC && !addr_from_pc)
      mem_addr = operand;
    mem_we    = (state == S_EXEC) && (op == 5'd3);
    mem_wdata = acc;
    in_ready  = (state == S_INPUT);
    halted    = (state == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= 7'd0;
      acc       <= 11'd0;
      neg       <= 1'b0;
      ir        <= 11'd0;
      out_data  <= 11'd0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= mem_rdata;
          pc    <= (pc == LAST_ADDR) ? 7'd0 : pc + 7'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            5'd1: begin
              acc <= wrap_data(sum);
              neg <= 1'b0;
            end
            5'd2: begin
              acc <= wrap_data(diff);
              neg <= diff[12];
            end
            5'd3: ;
            5'd5: begin
              acc <= sat_data(mem_rdata);
              neg <= 1'b0;
            end
            5'd6: pc <= operand;
            5'd7: if (acc == 11'd0 && !neg) pc <= operand;
            5'd8: if (!neg) pc <= operand;
            5'd9: begin
              if (ir == 11'd901) begin
                state <= S_INPUT;
              end else if (ir == 11'd902) begin
                out_data  <= acc;
                out_valid <= 1'b1;
                state     <= S_OUTPUT;
              end else begin
                state   <= S_HALT;
                illegal <= 1'b1;
              end
            end
            // Opcode 0 halts cleanly only for 000; 001..099 are illegal.
            5'd0: begin
              state   <= S_HALT;
              illegal <= (ir != 11'd0);
            end
            default: begin
              state   <= S_HALT;
              illegal <= 1'b1;
            end
          endcase
        end
        S_INPUT: begin
          if (in_valid) begin
            acc   <= sat_data(in_data);
            neg   <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
